// File: rtl/fixedpointquantizer.sv
// Requantizes wide signed products to BQ bits: round-half-up right shift, then saturate.
// Latency: 2 cycles (accepted at edge k, out_valid visible after edge k+1).
// Backpressure: two-deep pipeline; in_ready follows out_ready combinationally when full.
module fixedpointquantizer #(
    parameter int BP = 45,
    parameter int BQ = 8,
    parameter int BS = 6,
    parameter int BN = 16
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [BP-1:0] in_p,
    input  logic        [BS-1:0] in_shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [BQ-1:0] out_q,
    output logic                 out_sat,
    output logic        [BN-1:0] sat_cnt,
    input  logic                 cnt_clr
);

    localparam logic        [BS-1:0] SMAX = BS'(BP - 1);
    localparam logic signed [BP:0]   QMAX = (BP + 1)'((2 ** (BQ - 1)) - 1);
    localparam logic signed [BP:0]   QMIN = ~QMAX;

    logic                 v1, v2, en1, en2;
    logic        [BS-1:0] s;
    logic signed [BP:0]   ext, rnd, v1_d, v1_val;
    logic signed [BQ-1:0] q_d;
    logic                 sat_d;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1 && clr_n;
    assign out_valid = v2;

    // One guard bit above the product keeps the rounding add from overflowing.
    always_comb begin
        s    = (in_shift > SMAX) ? SMAX : in_shift;
        ext  = {in_p[BP-1], in_p};
        rnd  = '0;
        if (s != '0)
            rnd = (BP + 1)'(1) << (s - BS'(1));
        v1_d = (ext + rnd) >>> s;
    end

    always_comb begin
        q_d   = v1_val[BQ-1:0];
        sat_d = 1'b0;
        if (v1_val > QMAX) begin
            q_d   = {1'b0, {(BQ - 1){1'b1}}};
            sat_d = 1'b1;
        end else if (v1_val < QMIN) begin
            q_d   = {1'b1, {(BQ - 1){1'b0}}};
            sat_d = 1'b1;
        end
    end

    // Data registers only load with a valid sample so a stalled output stays put.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v1_val  <= '0;
            out_q   <= '0;
            out_sat <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid)
                    v1_val <= v1_d;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    out_q   <= q_d;
                    out_sat <= sat_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            sat_cnt <= '0;
        else if (cnt_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready && out_sat && (sat_cnt != {BN{1'b1}}))
            sat_cnt <= sat_cnt + BN'(1);
    end

endmodule

// File: doc/fixedpointquantizer.md
# fixedpointquantizer

Requantizes the wide signed products emitted by the MVP output scaler, (a+d)*b + c at BP bits, into narrow BQ-bit activations for the next layer. It applies an arithmetic right shift with round-half-up, then saturates to the signed BQ-bit range. It sits directly downstream of the scaler as the consuming end of that datapath, and adds a valid/ready handshake and a saturation event counter.

## Interface
- BP, 45: input product width (signed)
- BQ, 8: output width (signed), 2 ≤ BQ ≤ BP
- BS, 6: shift-amount width; 2^BS ≥ BP
- BN, 16: saturation counter width
- clk  in  1  clock, rising edge
- clr_n  in  1  reset; asynchronous assert, active-low; synchronous deassert is the integrator's responsibility
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_p  in  BP  signed product from the scaler
- in_shift  in  BS  right-shift amount, captured per sample with in_p
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts the sample
- out_q  out  BQ  signed quantized result
- out_sat  out  1  out_q was clipped (qualified by out_valid)
- sat_cnt  out  BN  count of saturated samples delivered
- cnt_clr  in  1  synchronous clear of sat_cnt

## Operation
- Transfer rules:
  - An input transfer happens when in_valid && in_ready at a clock edge.
  - An output transfer happens when out_valid && out_ready at a clock edge.
- Shift clamp: an effective shift of s = min(in_shift, BP-1) is applied.
- Stage 1 (round/shift):
  - Sign-extend in_p to BP+1 bits.
  - Add the rounding constant r = (s==0) ? 0 : 2^(s-1).
  - Arithmetic right shift by s; the result is the register v1_val.
  - Net effect is round-half-toward-+inf; the extra bit prevents overflow on the add.
- Stage 2 (saturate):
  - If v1_val > 2^(BQ-1)-1: out_q = 2^(BQ-1)-1, out_sat = 1.
  - If v1_val < -2^(BQ-1): out_q = -2^(BQ-1), out_sat = 1.
  - Otherwise: out_q = v1_val[BQ-1:0], out_sat = 0.
- Pipeline control: a two-register pipeline with valid bits v1 and v2.
  - en2 = !v2 || out_ready
  - en1 = !v1 || en2
  - in_ready = en1 && clr_n
- Stage 1 loads on en1; v1 <= in_valid.
- Stage 2 loads on en2; v2 <= v1.
- Data registers load only when their stage enable is high and the incoming valid is 1. Otherwise they hold, so a stalled out_q is stable.
- sat_cnt:
  - Increments by 1 on each output transfer with out_sat = 1.
  - Saturates at 2^BN-1; it never wraps.
  - cnt_clr = 1 sets it to 0 at the next edge and takes priority over a simultaneous increment.
- Ordering: samples exit in arrival order. No drops and no duplicates under any out_ready pattern.

## Timing
- Reset (clr_n low, immediate, asynchronous):
  - v1 = v2 = 0, so out_valid = 0.
  - out_q = 0, out_sat = 0, sat_cnt = 0.
  - in_ready = 0 while clr_n is low.
- First edge after clr_n rises: in_ready = 1; the pipeline is empty.
- Latency: a sample accepted at edge k has out_valid = 1 after edge k+1 (2-register pipeline, visible in cycle k+1 to k+2).
- Throughput: 1 sample/cycle while out_ready = 1.
- Backpressure:
  - With out_ready held 0, two samples are absorbed (v1, v2 full).
  - in_ready then drops combinationally in the same cycle.
  - in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- Simultaneous events:
  - When full, an output transfer and an input transfer in the same cycle are both accepted (in_ready = 1 via en2).
  - cnt_clr together with a saturated output transfer leaves sat_cnt = 0.
- Reset mid-stream: all in-flight samples are discarded, and no partial output appears after release.
- out_valid, once high, stays high with stable out_q/out_sat until the output transfer completes.

## Test plan
Parameters for all scenarios: BP=45, BQ=8.
1. Rounding. Stream these values with out_ready = 1:

   | in_p | in_shift | out_q |
   |---|---|---|
   | 100 | 2 | 25 |
   | 102 | 2 | 26 |
   | -102 | 2 | -25 |
   | -101 | 2 | -25 |
   | 6 | 2 | 2 |

   All have out_sat = 0, and each output appears 2 cycles after its input.
2. Saturation:
   - p=40000, s=4 → out_q=127, out_sat=1.
   - p=-40000, s=4 → out_q=-128, out_sat=1.
   - p=128, s=0 → 127, out_sat=1.
   - p=-128, s=0 → -128, out_sat=0.
   - Expect sat_cnt = 3.
3. Shift clamp: p = -(2^44), in_shift = 63 → effective s=44 → out_q = -1, out_sat = 0.
4. Backpressure: send 10 consecutive samples p=0..9 with s=0, with out_ready random at 50%.
   - in_ready falls within 2 accepts of any out_ready=0 run.
   - Outputs are exactly 0..9 in order.
   - out_q is stable while stalled.
5. Reset mid-stream: with two samples in flight, pulse clr_n low for half a cycle.
   - out_valid, out_q, out_sat and sat_cnt go to 0 immediately.
   - No stale sample emerges afterwards.
   - A new sample p=4, s=1 yields out_q=2.
6. Counter limits: with BN=2, deliver 5 saturated samples → sat_cnt = 3. Then assert cnt_clr in the same cycle as a saturated output transfer → sat_cnt = 0.
